// File: rtl/mhz1_bus_responder_if.sv
// Bus-side and register-port signals of the 1MHz-bus responder, grouped for port connection.
interface mhz1_bus_responder_if #(
   parameter int unsigned ADDR_BITS = 4
);
   logic                 clke;
   logic                 rnw;
   logic                 pgfc_n;
   logic                 pgfd_n;
   logic [7:0]           bus_addr;
   logic [7:0]           bus_data_in;
   logic [7:0]           bus_data_out;
   logic                 bus_data_oe;
   logic                 bus_data_dir;
   logic [ADDR_BITS-1:0] reg_addr;
   logic [7:0]           reg_wdata;
   logic                 reg_wr;
   logic                 reg_rd;
   logic [7:0]           reg_rdata;
   logic                 reg_page;

   modport master (
      output clke, rnw, pgfc_n, pgfd_n, bus_addr, bus_data_in, reg_rdata,
      input  bus_data_out, bus_data_oe, bus_data_dir,
             reg_addr, reg_wdata, reg_wr, reg_rd, reg_page
   );

   modport slave (
      input  clke, rnw, pgfc_n, pgfd_n, bus_addr, bus_data_in, reg_rdata,
      output bus_data_out, bus_data_oe, bus_data_dir,
             reg_addr, reg_wdata, reg_wr, reg_rd, reg_page
   );
endinterface

// File: rtl/mhz1_bus_responder.sv
// 1MHz-bus slave front end: synchronises host bus cycles into clk50 and turns them into register strobes.
// Optional page-FD decode is enabled by defining MHZ1_BUS_PGFD_EN.
module mhz1_bus_responder #(
   parameter logic [7:0]  BASE_ADDR   = 8'hA0,
   parameter int unsigned ADDR_BITS   = 4,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input logic                 clk50,
   input logic                 reset,
   mhz1_bus_responder_if.slave bus
);
   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACT_WR = 2'd1,
      ACT_RD = 2'd2,
      HOLD   = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 armed_q, armed_d;
   logic                 rd_p1_q, rd_p1_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]           reg_wdata_q, reg_wdata_d;
   logic                 reg_wr_q, reg_wr_d;
   logic                 reg_rd_q, reg_rd_d;
   logic [7:0]           dout_q, dout_d;
   logic                 oe_q, oe_d;
   logic                 dir_q;

   logic                 s1_clke_q, s2_clke_q;
   logic                 s1_rnw_q, s2_rnw_q;
   logic                 s1_pgfc_n_q, s2_pgfc_n_q;
   logic [7:0]           s1_addr_q, s2_addr_q;
   logic [7:0]           s1_data_q, s2_data_q;

   logic                 rise, fall, tag_match, sel_fc, sel, start;

   // Identical two-stage pipeline for every bus input keeps them mutually aligned.
   always_ff @(posedge clk50) begin
      s1_clke_q   <= bus.clke;
      s2_clke_q   <= s1_clke_q;
      s1_rnw_q    <= bus.rnw;
      s2_rnw_q    <= s1_rnw_q;
      s1_pgfc_n_q <= bus.pgfc_n;
      s2_pgfc_n_q <= s1_pgfc_n_q;
      s1_addr_q   <= bus.bus_addr;
      s2_addr_q   <= s1_addr_q;
      s1_data_q   <= bus.bus_data_in;
      s2_data_q   <= s1_data_q;
   end

   assign rise      = ~s2_clke_q & s1_clke_q;
   assign fall      = s2_clke_q & ~s1_clke_q;
   assign tag_match = (s2_addr_q[7:ADDR_BITS] == BASE_ADDR[7:ADDR_BITS]);
   assign sel_fc    = ~s2_pgfc_n_q & tag_match;

`ifdef MHZ1_BUS_PGFD_EN
   logic s1_pgfd_n_q, s2_pgfd_n_q, sel_fd, reg_page_q;

   always_ff @(posedge clk50) begin
      s1_pgfd_n_q <= bus.pgfd_n;
      s2_pgfd_n_q <= s1_pgfd_n_q;
   end

   assign sel_fd = ~s2_pgfd_n_q & tag_match;
   assign sel    = sel_fc | sel_fd;

   // FC takes priority when both page selects are low.
   always_ff @(posedge clk50) begin
      if (reset)      reg_page_q <= 1'b0;
      else if (start) reg_page_q <= ~sel_fc;
   end

   assign bus.reg_page = reg_page_q;
`else
   assign sel          = sel_fc;
   assign bus.reg_page = 1'b0;
`endif

   // armed_q demands a seen rise, so a cycle already in progress at reset release is skipped.
   assign start = (state_q == IDLE) & armed_q & s1_clke_q & s2_clke_q & sel;

   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q     <= IDLE;
         armed_q     <= 1'b0;
         rd_p1_q     <= 1'b0;
         cnt_q       <= '0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         dout_q      <= '0;
         oe_q        <= 1'b0;
         dir_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         rd_p1_q     <= rd_p1_d;
         cnt_q       <= cnt_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wr_q    <= reg_wr_d;
         reg_rd_q    <= reg_rd_d;
         dout_q      <= dout_d;
         oe_q        <= oe_d;
         dir_q       <= oe_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      rd_p1_d     = 1'b0;
      cnt_d       = cnt_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wr_d    = 1'b0;
      reg_rd_d    = 1'b0;
      dout_d      = dout_q;
      oe_d        = oe_q;

      if (rise) armed_d = 1'b1;
      if (fall) armed_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            oe_d = 1'b0;
            if (start) begin
               armed_d    = 1'b0;
               reg_addr_d = s2_addr_q[ADDR_BITS-1:0];
               if (s2_rnw_q) begin
                  state_d  = ACT_RD;
                  reg_rd_d = 1'b1;
               end else begin
                  state_d  = ACT_WR;
               end
            end
         end
         // The s2 data on the fall cycle was sampled while clke was still high.
         ACT_WR: begin
            reg_wdata_d = s2_data_q;
            if (fall) begin
               state_d  = IDLE;
               reg_wr_d = 1'b1;
            end
         end
         ACT_RD: begin
            rd_p1_d = reg_rd_q;
            if (rd_p1_q) begin
               dout_d = bus.reg_rdata;
               oe_d   = 1'b1;
            end
            if (fall) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               state_d = IDLE;
               oe_d    = 1'b0;
               dout_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.reg_addr     = reg_addr_q;
   assign bus.reg_wdata    = reg_wdata_q;
   assign bus.reg_wr       = reg_wr_q;
   assign bus.reg_rd       = reg_rd_q;
   assign bus.bus_data_out = dout_q;
   assign bus.bus_data_oe  = oe_q;
   assign bus.bus_data_dir = dir_q;
endmodule

// File: tb/tb_mhz1_bus_responder.sv
// Self-checking bench for mhz1_bus_responder: directed bus cycles plus random traffic against a transaction model.
module tb_mhz1_bus_responder;
   localparam int unsigned ADDR_BITS   = 4;
   localparam int unsigned HOLD_CYCLES = 4;
   localparam logic [7:0]  BASE_ADDR   = 8'hA0;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
      logic       pg;
   } wr_t;

   typedef struct packed {
      logic [3:0] a;
      logic       pg;
   } rd_t;

   logic clk50 = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   wr_t        exp_wr_q[$];
   rd_t        exp_rd_q[$];
   logic [7:0] model_regs [32];
   logic [7:0] dev_regs   [32];

   mhz1_bus_responder_if #(.ADDR_BITS(ADDR_BITS)) bif ();

   mhz1_bus_responder #(
      .BASE_ADDR  (BASE_ADDR),
      .ADDR_BITS  (ADDR_BITS),
      .HOLD_CYCLES(HOLD_CYCLES)
   ) dut (
      .clk50(clk50),
      .reset(reset),
      .bus  (bif)
   );

   always #10 clk50 = ~clk50;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Decode rule from the window/page definition: returns {selected, page}.
   function automatic logic [1:0] decode(input logic fc_n, input logic fd_n, input logic [7:0] a);
      logic in_win;
      in_win = (a[7:4] == BASE_ADDR[7:4]);
      if (!fc_n && in_win) return 2'b10;
`ifdef MHZ1_BUS_PGFD_EN
      if (!fd_n && in_win) return 2'b11;
`else
      if (fd_n === 1'bx) return 2'b00;
`endif
      return 2'b00;
   endfunction

   // Register device behind the port: read data appears one cycle after reg_rd, junk otherwise.
   always @(posedge clk50) begin
      if (bif.reg_wr) dev_regs[{bif.reg_page, bif.reg_addr}] <= bif.reg_wdata;
      if (bif.reg_rd) bif.reg_rdata <= dev_regs[{bif.reg_page, bif.reg_addr}];
      else            bif.reg_rdata <= 8'($urandom);
   end

   // Strobe monitor: every strobe must match the next expected transaction.
   always @(negedge clk50) begin
      if (!reset) begin
         if (bif.reg_wr) begin
            wr_t e;
            check_eq("wr_excl", {30'd0, bif.reg_wr, bif.reg_rd}, 32'd2);
            check_eq("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) begin
               e = exp_wr_q.pop_front();
               check_eq("wr_addr", 32'(bif.reg_addr), 32'(e.a));
               check_eq("wr_data", 32'(bif.reg_wdata), 32'(e.d));
               check_eq("wr_page", 32'(bif.reg_page), 32'(e.pg));
            end
         end
         if (bif.reg_rd) begin
            rd_t e;
            check_eq("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
            if (exp_rd_q.size() != 0) begin
               e = exp_rd_q.pop_front();
               check_eq("rd_addr", 32'(bif.reg_addr), 32'(e.a));
               check_eq("rd_page", 32'(bif.reg_page), 32'(e.pg));
            end
         end
      end
   end

   task automatic idle_bus();
      bif.rnw         = 1'b1;
      bif.pgfc_n      = 1'b1;
      bif.pgfd_n      = 1'b1;
      bif.bus_addr    = 8'($urandom);
      bif.bus_data_in = 8'($urandom);
   endtask

   // One complete host bus cycle; bus edges land 1ns after a clk50 rising edge.
   task automatic bus_cycle(input logic rnw_v, input logic fc_n, input logic fd_n,
                            input logic [7:0] a, input logic [7:0] d);
      int         lo, hi, cnt;
      logic [1:0] dec;
      logic [7:0] exp_rd;
      lo  = int'($urandom_range(20, 30));
      hi  = int'($urandom_range(20, 30));
      dec = decode(fc_n, fd_n, a);
      exp_rd = model_regs[{dec[0], a[3:0]}];
      if (dec[1] && !rnw_v) begin
         exp_wr_q.push_back('{a: a[3:0], d: d, pg: dec[0]});
         model_regs[{dec[0], a[3:0]}] = d;
      end
      if (dec[1] && rnw_v) exp_rd_q.push_back('{a: a[3:0], pg: dec[0]});

      @(posedge clk50); #1;
      bif.rnw = rnw_v; bif.pgfc_n = fc_n; bif.pgfd_n = fd_n; bif.bus_addr = a;
      bif.bus_data_in = 8'($urandom);
      repeat (lo) @(posedge clk50);
      #1 bif.clke = 1'b1;
      repeat (hi / 2) @(posedge clk50);
      #1 if (!rnw_v) bif.bus_data_in = d;
      repeat (hi - hi / 2 - 1) @(posedge clk50);
      @(negedge clk50);
      if (dec[1] && rnw_v) begin
         check_eq("rd_oe_before_fall", 32'(bif.bus_data_oe), 32'd1);
         check_eq("rd_dir_before_fall", 32'(bif.bus_data_dir), 32'd1);
         check_eq("rd_data", 32'(bif.bus_data_out), 32'(exp_rd));
      end else begin
         check_eq("oe_idle_or_wr", 32'(bif.bus_data_oe), 32'd0);
      end
      @(posedge clk50); #1;
      bif.clke = 1'b0;
      idle_bus();
      if (dec[1] && rnw_v) begin
         cnt = 0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk50);
            if (bif.bus_data_oe) cnt++;
            else break;
         end
         // Two synchroniser stages of detection delay precede the hold window.
         check_eq("rd_hold_cycles", 32'(cnt), 32'(HOLD_CYCLES + 2));
         check_eq("rd_data_cleared", 32'(bif.bus_data_out), 32'd0);
         check_eq("rd_dir_cleared", 32'(bif.bus_data_dir), 32'd0);
      end
      repeat (8) @(posedge clk50);
      check_eq("wr_all_seen", 32'(exp_wr_q.size()), 32'd0);
      check_eq("rd_all_seen", 32'(exp_rd_q.size()), 32'd0);
   endtask

   // Bus cycle interrupted by a reset pulse while clke is high; no strobe may follow it.
   task automatic aborted_cycle(input logic rnw_v, input logic [7:0] a, input logic [7:0] d);
      if (rnw_v) exp_rd_q.push_back('{a: a[3:0], pg: 1'b0});
      @(posedge clk50); #1;
      bif.rnw = rnw_v; bif.pgfc_n = 1'b0; bif.pgfd_n = 1'b1; bif.bus_addr = a; bif.bus_data_in = d;
      repeat (20) @(posedge clk50);
      #1 bif.clke = 1'b1;
      repeat (12) @(posedge clk50);
      @(negedge clk50);
      check_eq("abort_oe_pre", 32'(bif.bus_data_oe), rnw_v ? 32'd1 : 32'd0);
      @(posedge clk50); #1 reset = 1'b1;
      @(posedge clk50);
      @(negedge clk50);
      check_eq("abort_oe_released", 32'(bif.bus_data_oe), 32'd0);
      check_eq("abort_dir_released", 32'(bif.bus_data_dir), 32'd0);
      @(posedge clk50); #1 reset = 1'b0;
      repeat (8) @(posedge clk50);
      #1 bif.clke = 1'b0;
      idle_bus();
      repeat (20) @(posedge clk50);
      check_eq("abort_no_wr", 32'(exp_wr_q.size()), 32'd0);
      check_eq("abort_rd_seen", 32'(exp_rd_q.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         model_regs[i] = 8'h00;
         dev_regs[i]   = 8'h00;
      end
      bif.clke = 1'b0;
      idle_bus();
      repeat (5) @(posedge clk50);
      @(negedge clk50);
      check_eq("rst_dout", 32'(bif.bus_data_out), 32'd0);
      check_eq("rst_oe", 32'(bif.bus_data_oe), 32'd0);
      check_eq("rst_dir", 32'(bif.bus_data_dir), 32'd0);
      check_eq("rst_addr", 32'(bif.reg_addr), 32'd0);
      check_eq("rst_wdata", 32'(bif.reg_wdata), 32'd0);
      check_eq("rst_wr", 32'(bif.reg_wr), 32'd0);
      check_eq("rst_rd", 32'(bif.reg_rd), 32'd0);
      check_eq("rst_page", 32'(bif.reg_page), 32'd0);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk50);

      bus_cycle(1'b0, 1'b0, 1'b1, 8'hA0, 8'h10);
      bus_cycle(1'b0, 1'b0, 1'b1, 8'hA4, 8'hA8);
      bus_cycle(1'b0, 1'b0, 1'b1, 8'hA5, 8'h19);
      bus_cycle(1'b0, 1'b0, 1'b1, 8'hA6, 8'hA0);
      bus_cycle(1'b0, 1'b0, 1'b1, 8'hA7, 8'h00);
      bus_cycle(1'b0, 1'b0, 1'b1, 8'hA8, 8'h04);
      bus_cycle(1'b0, 1'b0, 1'b1, 8'hB0, 8'h55);
      bus_cycle(1'b0, 1'b1, 1'b1, 8'hA0, 8'h66);
      bus_cycle(1'b1, 1'b0, 1'b1, 8'hA5, 8'h00);
      aborted_cycle(1'b0, 8'hA3, 8'h5A);
      bus_cycle(1'b0, 1'b0, 1'b1, 8'hA3, 8'h77);
      bus_cycle(1'b1, 1'b0, 1'b1, 8'hA3, 8'h00);
      aborted_cycle(1'b1, 8'hA7, 8'h00);
      bus_cycle(1'b0, 1'b1, 1'b0, 8'hA2, 8'h33);
      bus_cycle(1'b0, 1'b0, 1'b0, 8'hA9, 8'h3C);

      for (int n = 0; n < 60; n++) begin
         logic [7:0] a;
         a = 8'($urandom);
         if ($urandom_range(0, 3) != 0) a[7:4] = BASE_ADDR[7:4];
         bus_cycle(1'($urandom), ($urandom_range(0, 6) == 0), 1'($urandom), a, 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
